sdp_ram_arbiter: RTL and testbench
==================================

# sdp_ram_arbiter

Single-clock arbiter that shares one simple dual-port RAM (write port A, read port B, `ena`/`wea`/`addra`/`dina`/`enb`/`addrb`/`doutb`) between two requesters.

- Each port has its own round-robin arbiter.
- Write/read address collisions in the same cycle are resolved in favour of the write.
- Read responses are routed back to the requester that issued them, after the RAM's fixed read latency.
- The block sits directly in front of the RAM instance; requesters never drive the RAM themselves.

## Interface

Parameters:
- `ADDR_W`, default 10: RAM address width.
- `DATA_W`, default 32: RAM data width.
- `RD_LAT`, default 1: RAM read latency in cycles, from `enb` high to valid `doutb`. Legal range is 1..4.

Ports (requester index `i` is 0..1; per-requester buses are packed `[1:0][W-1:0]` arrays):
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`, in, 1: clock for the block and for both RAM ports.
  - `rst_n`, in, 1: asynchronous active-low reset.
- Write requests:
  - `wr_req`, in, 2: write request per requester. Held until granted.
  - `wr_addr`, in, 2×ADDR_W: write address per requester.
  - `wr_data`, in, 2×DATA_W: write data per requester.
  - `wr_gnt`, out, 2: one-hot or zero. The write is accepted in this cycle.
- Read requests:
  - `rd_req`, in, 2: read request per requester. Held until granted.
  - `rd_addr`, in, 2×ADDR_W: read address per requester.
  - `rd_gnt`, out, 2: one-hot or zero. The read is issued in this cycle.
- Read responses:
  - `rd_rvalid`, out, 2: one-hot or zero. Read data is valid for requester `i`.
  - `rd_rdata`, out, DATA_W: equal to `ram_doutb`, shared by both requesters. Qualify it with `rd_rvalid`.
- RAM write port:
  - `ram_ena`, out, 1: driven high when any write is granted.
  - `ram_wea`, out, 1: write enable.
  - `ram_addra`, out, ADDR_W: write address.
  - `ram_dina`, out, DATA_W: write data.
- RAM read port:
  - `ram_enb`, out, 1: driven high when any read is granted.
  - `ram_addrb`, out, ADDR_W: read address.
  - `ram_doutb`, in, DATA_W: RAM read data.

## Operation

- **Write arbitration:** a 2-way round-robin arbiter over `wr_req`.
  - A 1-bit priority pointer `wr_ptr` names the preferred requester.
  - When the winner is granted, `wr_ptr` is set to the other index.
  - The pointer does not change when there is no grant.
- **Read arbitration:** an identical, independent arbiter over `rd_req`, with its own pointer `rd_ptr`.
- **Grant timing:** grants and RAM port signals are combinational from the current requests and the registered pointers.
  - A granted request is accepted in the same cycle.
  - The requester may change or drop its request in the following cycle.
- **RAM write port:** on a write grant to requester `i`:
  - `ram_ena` = `ram_wea` = 1;
  - `ram_addra` = `wr_addr[i]`;
  - `ram_dina` = `wr_data[i]`.
  - With no write grant, `ram_ena` = `ram_wea` = 0, and `addra`/`dina` hold the value of requester `wr_ptr` (don't-care).
- **Collision rule:** if the read winner's address equals the granted write address in the same cycle:
  - the read is not granted, and `rd_gnt` is 0;
  - `ram_enb` is 0;
  - `rd_ptr` is unchanged.
  - The read retries next cycle and therefore returns the newly written data. The RAM is read-first; the block never relies on that.
- **Read tag pipeline:** a shift register `RD_LAT` stages deep, each stage holding {valid, requester id}.
  - A read grant inserts {1, `i`} at stage 0.
  - The output stage drives `rd_rvalid[id]`.
  - Throughput is one read per cycle; the pipeline never stalls.
- **No backpressure on responses:** requesters must accept `rd_rvalid` whenever it is asserted.

## Timing

- **Reset values:**
  - `wr_ptr` = `rd_ptr` = 0.
  - Every tag-pipeline stage is invalid.
  - `rd_rvalid` = 0.
  - While `rst_n` is low, `wr_gnt`, `rd_gnt`, `ram_ena`, `ram_wea` and `ram_enb` are forced to 0.
- **Read latency:** `rd_rvalid[i]` rises exactly `RD_LAT` cycles after the cycle in which `rd_gnt[i]` is high.
- **Write latency:** data written in cycle N is readable by a read granted in cycle N+1 or later.
- **Simultaneous write and read to different addresses:** both are granted in the same cycle.
- **Both requesters requesting continuously:** grants alternate every cycle, starting with requester 0 after reset.
- **Reset mid-operation:** in-flight reads are discarded, and no `rd_rvalid` follows the release of reset. A write granted in the cycle reset asserts is not guaranteed to reach the RAM.

## Structure

- **Package `sdp_arb_pkg`:**
  - `N_REQ` = 2;
  - `req_id_t` (logic [0:0]);
  - `rd_tag_t` struct {logic vld; req_id_t id;};
  - default `ADDR_W`/`DATA_W` constants, kept consistent with the shared RAM defines.
- **Sub-module `rr_arb2`:** the 2-way round-robin arbiter with an enable input, taking `req[1:0]` and `en` and producing `gnt[1:0]` and the registered pointer. It is instantiated twice, once for writes and once for reads.
  - For the read instance, `en` is low on a collision, which blocks both the grant and the pointer update.

## Test plan

1. **Basic write then read.** Write from requester 0, addr 5, data 32'hA5A5_0005 → `wr_gnt` = 2'b01, `ram_addra` = 5, `ram_wea` = 1. Next cycle, read from requester 1, addr 5 → `rd_rvalid` = 2'b10 after `RD_LAT` cycles, with `rd_rdata` = 32'hA5A5_0005.
2. **Write fairness.** Both `wr_req` held high for 6 cycles after reset → `wr_gnt` sequence 01, 10, 01, 10, 01, 10. Same check for reads.
3. **Collision.** Requester 0 writes addr 7 / 32'h77 and requester 1 reads addr 7 in the same cycle → `rd_gnt` = 0 and `ram_enb` = 0 that cycle. The read is granted the next cycle and returns 32'h77.
4. **Response routing.** With `RD_LAT` = 2, back-to-back reads from requester 0 (addr 1) then requester 1 (addr 2) → `rd_rvalid` is 01 then 10 on consecutive cycles, carrying mem[1] then mem[2].
5. **Reset with a read in flight.** Grant a read, then pull `rst_n` low for 1 cycle before the response → `rd_rvalid` stays 0. After reset, both-requester contention grants requester 0 first.
6. **Different addresses, same cycle.** Write addr 3 and read addr 4 in the same cycle → both granted; `ram_ena` and `ram_enb` are both 1.

Source files
------------

// File: rtl/sdp_arb_pkg.sv
// Shared types and defaults for the simple dual-port RAM arbiter.
package sdp_arb_pkg;

    localparam int unsigned N_REQ      = 2;
    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;

    typedef logic [0:0] req_id_t;

    typedef struct packed {
        logic    vld;
        req_id_t id;
    } rd_tag_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a registered priority pointer.
// A low enable blocks both the grant and the pointer update.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt,
    output logic       ptr
);

    logic ptr_d, ptr_q;
    logic other;

    assign other = ~ptr_q;

    always_comb begin
        gnt   = 2'b00;
        ptr_d = ptr_q;
        // Grants are suppressed while reset is asserted.
        if (rst_n && en) begin
            if (req[ptr_q]) begin
                gnt[ptr_q] = 1'b1;
                ptr_d      = other;
            end else if (req[other]) begin
                gnt[other] = 1'b1;
                ptr_d      = ptr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/sdp_ram_arbiter.sv
// Shares one simple dual-port RAM between two requesters: independent round-robin
// arbitration per port, write-wins on same-address collisions, tagged read returns.
module sdp_ram_arbiter
    import sdp_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,

    input  logic [1:0]             wr_req,
    input  logic [1:0][ADDR_W-1:0] wr_addr,
    input  logic [1:0][DATA_W-1:0] wr_data,
    output logic [1:0]             wr_gnt,

    input  logic [1:0]             rd_req,
    input  logic [1:0][ADDR_W-1:0] rd_addr,
    output logic [1:0]             rd_gnt,

    output logic [1:0]             rd_rvalid,
    output logic [DATA_W-1:0]      rd_rdata,

    output logic                   ram_ena,
    output logic                   ram_wea,
    output logic [ADDR_W-1:0]      ram_addra,
    output logic [DATA_W-1:0]      ram_dina,

    output logic                   ram_enb,
    output logic [ADDR_W-1:0]      ram_addrb,
    input  logic [DATA_W-1:0]      ram_doutb
);

    logic    wr_ptr, rd_ptr;
    req_id_t wr_id, rd_id;
    logic    collide;
    rd_tag_t tag_in;
    rd_tag_t tag_q [RD_LAT];

    rr_arb2 u_wr_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (wr_req),
        .en    (1'b1),
        .gnt   (wr_gnt),
        .ptr   (wr_ptr)
    );

    // Write side: the granted requester, else the preferred one (address is don't-care).
    always_comb begin
        if (wr_gnt[1]) begin
            wr_id = 1'b1;
        end else if (wr_gnt[0]) begin
            wr_id = 1'b0;
        end else begin
            wr_id = wr_ptr;
        end
    end

    assign ram_ena   = |wr_gnt;
    assign ram_wea   = ram_ena;
    assign ram_addra = wr_addr[wr_id];
    assign ram_dina  = wr_data[wr_id];

    // Read candidate is chosen before enable so its address can be checked for a collision.
    assign rd_id   = rd_req[rd_ptr] ? rd_ptr : ~rd_ptr;
    assign collide = ram_ena && (|rd_req) && (rd_addr[rd_id] == ram_addra);

    rr_arb2 u_rd_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (rd_req),
        .en    (~collide),
        .gnt   (rd_gnt),
        .ptr   (rd_ptr)
    );

    assign ram_enb   = |rd_gnt;
    assign ram_addrb = rd_addr[rd_id];
    assign rd_rdata  = ram_doutb;

    always_comb begin
        tag_in     = '0;
        tag_in.vld = |rd_gnt;
        tag_in.id  = rd_gnt[1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < RD_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            tag_q[0] <= tag_in;
            for (int k = 1; k < RD_LAT; k++) begin
                tag_q[k] <= tag_q[k-1];
            end
        end
    end

    always_comb begin
        rd_rvalid = 2'b00;
        if (tag_q[RD_LAT-1].vld) begin
            rd_rvalid[tag_q[RD_LAT-1].id] = 1'b1;
        end
    end

endmodule

// File: tb/tb_sdp_ram_arbiter.sv
// Bench for sdp_ram_arbiter: directed scenarios plus random traffic against a
// queue-based reference model and a behavioural RAM with RD_LAT read latency.
module tb_sdp_ram_arbiter;

    localparam int unsigned AW  = 10;
    localparam int unsigned DW  = 32;
    localparam int unsigned LAT = 2;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [1:0]          wr_req, rd_req;
    logic [1:0][AW-1:0]  wr_addr, rd_addr;
    logic [1:0][DW-1:0]  wr_data;
    logic [1:0]          wr_gnt, rd_gnt, rd_rvalid;
    logic [DW-1:0]       rd_rdata;
    logic                ram_ena, ram_wea, ram_enb;
    logic [AW-1:0]       ram_addra, ram_addrb;
    logic [DW-1:0]       ram_dina, ram_doutb;

    always #5 clk = ~clk;

    sdp_ram_arbiter #(
        .ADDR_W (AW),
        .DATA_W (DW),
        .RD_LAT (LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_rvalid (rd_rvalid),
        .rd_rdata  (rd_rdata),
        .ram_ena   (ram_ena),
        .ram_wea   (ram_wea),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_enb   (ram_enb),
        .ram_addrb (ram_addrb),
        .ram_doutb (ram_doutb)
    );

    // Behavioural RAM: read-first, LAT-cycle read pipeline.
    logic [DW-1:0] mem   [1024];
    logic [DW-1:0] rpipe [LAT];
    always @(posedge clk) begin
        if (ram_enb) rpipe[0] <= mem[ram_addrb];
        for (int k = 1; k < LAT; k++) rpipe[k] <= rpipe[k-1];
        if (ram_ena && ram_wea) mem[ram_addra] <= ram_dina;
    end
    assign ram_doutb = rpipe[LAT-1];

    // Reference model state
    typedef struct {
        int          due;
        int          id;
        logic [31:0] data;
    } resp_t;

    int          n_cmp  = 0;
    int          n_fail = 0;
    int          cyc    = 0;
    int          wp, rp;
    int          last_w, last_r;
    logic [31:0] smem [16];
    resp_t       pq [$];
    logic [1:0]  obs_wgnt, obs_rgnt, obs_rvalid;
    logic        obs_ena, obs_enb, obs_wea;
    logic [31:0] obs_rdata, obs_addra;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: called just after a falling edge with inputs already driven.
    task automatic step();
        int          w, r;
        logic [1:0]  ew, er, ev;
        logic [31:0] edata;
        #1;
        obs_wgnt = wr_gnt;  obs_rgnt = rd_gnt;  obs_rvalid = rd_rvalid;
        obs_ena = ram_ena;  obs_enb = ram_enb;  obs_wea = ram_wea;
        obs_rdata = rd_rdata; obs_addra = 32'(ram_addra);
        w = -1; r = -1;
        if (wr_req[wp]) w = wp; else if (wr_req[1-wp]) w = 1 - wp;
        if (rd_req[rp]) r = rp; else if (rd_req[1-rp]) r = 1 - rp;
        if (w >= 0 && r >= 0 && rd_addr[r] == wr_addr[w]) r = -1;
        ew = 2'b00; er = 2'b00; ev = 2'b00; edata = '0;
        if (w >= 0) ew[w] = 1'b1;
        if (r >= 0) er[r] = 1'b1;
        if (pq.size() > 0 && pq[0].due == cyc) begin
            ev[pq[0].id] = 1'b1;
            edata = pq[0].data;
            void'(pq.pop_front());
        end
        check("wr_gnt", 64'(wr_gnt), 64'(ew));
        check("rd_gnt", 64'(rd_gnt), 64'(er));
        check("ram_ena", 64'(ram_ena), 64'(w >= 0));
        check("ram_wea", 64'(ram_wea), 64'(w >= 0));
        check("ram_enb", 64'(ram_enb), 64'(r >= 0));
        check("rd_rvalid", 64'(rd_rvalid), 64'(ev));
        if (w >= 0) begin
            check("ram_addra", 64'(ram_addra), 64'(wr_addr[w]));
            check("ram_dina", 64'(ram_dina), 64'(wr_data[w]));
        end
        if (r >= 0) check("ram_addrb", 64'(ram_addrb), 64'(rd_addr[r]));
        if (ev != 2'b00) check("rd_rdata", 64'(rd_rdata), 64'(edata));
        if (r >= 0) begin
            pq.push_back('{due: cyc + LAT, id: r, data: smem[rd_addr[r][3:0]]});
            rp = 1 - r;
        end
        if (w >= 0) begin
            smem[wr_addr[w][3:0]] = wr_data[w];
            wp = 1 - w;
        end
        last_w = w; last_r = r;
        cyc++;
        @(negedge clk);
    endtask

    // Hold reset low across one rising edge, with requests active.
    task automatic reset_pulse();
        logic [1:0] sw, sr;
        sw = wr_req; sr = rd_req;
        wr_req = 2'b11; rd_req = 2'b11;
        rst_n = 1'b0;
        #1;
        check("rst wr_gnt", 64'(wr_gnt), 64'd0);
        check("rst rd_gnt", 64'(rd_gnt), 64'd0);
        check("rst ram_ena", 64'(ram_ena), 64'd0);
        check("rst ram_wea", 64'(ram_wea), 64'd0);
        check("rst ram_enb", 64'(ram_enb), 64'd0);
        check("rst rd_rvalid", 64'(rd_rvalid), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wr_req = sw; rd_req = sr;
        wp = 0; rp = 0;
        pq.delete();
        cyc++;
    endtask

    task automatic idle(input int n);
        wr_req = 2'b00; rd_req = 2'b00;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        rst_n = 1'b1;
        wr_req = '0; rd_req = '0; wr_addr = '0; rd_addr = '0; wr_data = '0;
        for (int k = 0; k < 16; k++) smem[k] = '0;
        wp = 0; rp = 0;
        #1;
        @(negedge clk);
        reset_pulse();

        // Preload addresses 0..15 so every later read has a known value.
        for (int a = 0; a < 16; a++) begin
            wr_req = 2'b01; wr_addr[0] = AW'(a); wr_data[0] = {16'hD0D0, 16'(a)};
            step();
        end
        idle(1);
        reset_pulse();

        // Fairness from reset on both ports, non-colliding addresses.
        wr_req = 2'b11; wr_addr[0] = 10; wr_addr[1] = 11;
        wr_data[0] = 32'h1010_0000; wr_data[1] = 32'h1111_0000;
        rd_req = 2'b11; rd_addr[0] = 12; rd_addr[1] = 13;
        for (int k = 0; k < 6; k++) begin
            step();
            check("fair wr", 64'(obs_wgnt), (k % 2 == 0) ? 64'd1 : 64'd2);
            check("fair rd", 64'(obs_rgnt), (k % 2 == 0) ? 64'd1 : 64'd2);
        end
        idle(LAT + 1);

        // Basic write then read by the other requester.
        wr_req = 2'b01; wr_addr[0] = 5; wr_data[0] = 32'hA5A5_0005;
        step();
        check("t1 wr_gnt", 64'(obs_wgnt), 64'd1);
        check("t1 addra", 64'(obs_addra), 64'd5);
        check("t1 wea", 64'(obs_wea), 64'd1);
        wr_req = 2'b00; rd_req = 2'b10; rd_addr[1] = 5;
        step();
        rd_req = 2'b00;
        for (int k = 0; k < LAT; k++) step();
        check("t1 rvalid", 64'(obs_rvalid), 64'd2);
        check("t1 rdata", 64'(obs_rdata), 64'hA5A5_0005);

        // Same-address collision: write wins, read retries next cycle.
        wr_req = 2'b01; wr_addr[0] = 7; wr_data[0] = 32'h77;
        rd_req = 2'b10; rd_addr[1] = 7;
        step();
        check("t3 rd_gnt", 64'(obs_rgnt), 64'd0);
        check("t3 enb", 64'(obs_enb), 64'd0);
        wr_req = 2'b00;
        step();
        check("t3 retry", 64'(obs_rgnt), 64'd2);
        rd_req = 2'b00;
        for (int k = 0; k < LAT; k++) step();
        check("t3 rvalid", 64'(obs_rvalid), 64'd2);
        check("t3 rdata", 64'(obs_rdata), 64'h77);

        // Back-to-back responses routed to the right requester.
        rd_req = 2'b01; rd_addr[0] = 1;
        step();
        rd_req = 2'b10; rd_addr[1] = 2;
        step();
        rd_req = 2'b00;
        step();
        check("t4 rvalid0", 64'(obs_rvalid), 64'd1);
        check("t4 rdata0", 64'(obs_rdata), 64'hD0D0_0001);
        step();
        check("t4 rvalid1", 64'(obs_rvalid), 64'd2);
        check("t4 rdata1", 64'(obs_rdata), 64'hD0D0_0002);

        // Different addresses in the same cycle: both granted.
        wr_req = 2'b01; wr_addr[0] = 3; wr_data[0] = 32'h3333;
        rd_req = 2'b01; rd_addr[0] = 4;
        step();
        check("t6 ena", 64'(obs_ena), 64'd1);
        check("t6 enb", 64'(obs_enb), 64'd1);
        idle(LAT + 1);

        // Reset with a read in flight discards the response.
        rd_req = 2'b01; rd_addr[0] = 6;
        step();
        rd_req = 2'b00;
        reset_pulse();
        for (int k = 0; k < LAT + 1; k++) begin
            step();
            check("t5 no rvalid", 64'(obs_rvalid), 64'd0);
        end
        wr_req = 2'b11; wr_addr[0] = 8; wr_addr[1] = 9;
        rd_req = 2'b11; rd_addr[0] = 14; rd_addr[1] = 15;
        step();
        check("t5 wr first", 64'(obs_wgnt), 64'd1);
        check("t5 rd first", 64'(obs_rgnt), 64'd1);
        idle(LAT + 1);

        // Random traffic; requests are held until the model says they were granted.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!wr_req[i] || last_w == i) begin
                    wr_req[i]  = 1'($urandom_range(0, 1));
                    wr_addr[i] = AW'($urandom_range(0, 15));
                    wr_data[i] = $urandom;
                end
                if (!rd_req[i] || last_r == i) begin
                    rd_req[i]  = 1'($urandom_range(0, 1));
                    rd_addr[i] = AW'($urandom_range(0, 15));
                end
            end
            step();
        end
        idle(LAT + 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
